// File: rtl/cska_pkg.sv
// Shared definitions for the pipelined carry-skip subtractor.
package cska_pkg;

    localparam int CSKA_WIDTH = 16;
    localparam int CSKA_BLK   = 4;

    // Number of carry-skip blocks, which is also the number of pipeline stages.
    function automatic int nblk(input int width, input int blk);
        return width / blk;
    endfunction

    // Control part of a stage record: valid bit, carry into the next block,
    // and the two operand sign facts the overflow flag needs at the end.
    typedef struct packed {
        logic valid;
        logic cin;
        logic sa;
        logic sx;
    } cska_ctl_t;

    // Full per-stage record at the default width. Inside the pipe the diff and
    // operand fields are narrowed stage by stage to the bits still live.
    typedef struct packed {
        cska_ctl_t               ctl;
        logic [CSKA_WIDTH-1:0]   diff;
        logic [CSKA_WIDTH-1:0]   opa;
        logic [CSKA_WIDTH-1:0]   opb_n;
    } cska_stage_t;

endpackage

// File: rtl/cska_block.sv
// Combinational BLK-bit carry-skip slice computing a + b_n + cin.
module cska_block
    import cska_pkg::*;
#(
    parameter int BLK = CSKA_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b_n,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           prop
);

    logic [BLK-1:0] p;
    logic           rc;

    // Ripple the carry through the slice; skip the whole slice when every bit propagates.
    always_comb begin
        p   = a ^ b_n;
        rc  = cin;
        sum = '0;
        for (int i = 0; i < BLK; i++) begin
            sum[i] = p[i] ^ rc;
            rc     = (a[i] & b_n[i]) | (p[i] & rc);
        end
        prop = &p;
        cout = prop ? cin : rc;
    end

endmodule

// File: rtl/carryskip_subtractor_pipe.sv
// Pipelined subtractor diff = a - b - bin, one carry-skip block per stage,
// valid/ready on both sides with a single global advance.
module carryskip_subtractor_pipe
    import cska_pkg::*;
#(
    parameter int WIDTH = CSKA_WIDTH,
    parameter int BLK   = CSKA_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NBLK = nblk(WIDTH, BLK);

    logic adv;

    // The whole pipe moves together whenever the output slot is free or being drained.
    always_comb begin
        adv      = ~out_valid | out_ready;
        in_ready = adv;
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int REM = WIDTH - k * BLK;

        cska_ctl_t              ctl_in;
        cska_ctl_t              ctl_d;
        cska_ctl_t              ctl_q;
        logic [REM-1:0]         opa_in;
        logic [REM-1:0]         opb_n_in;
        logic [(k+1)*BLK-1:0]   diff_d;
        logic [(k+1)*BLK-1:0]   diff_q;
        logic [BLK-1:0]         blk_sum;
        logic                   blk_cout;
        logic                   blk_prop;

        if (k == 0) begin : g_src
            // Admit new operands as a + ~b + ~bin; a bubble enters as an all-zero record.
            always_comb begin
                ctl_in   = '0;
                opa_in   = '0;
                opb_n_in = '0;
                if (in_valid) begin
                    ctl_in.valid = 1'b1;
                    ctl_in.cin   = ~bin;
                    ctl_in.sa    = a[WIDTH-1];
                    ctl_in.sx    = a[WIDTH-1] ^ b[WIDTH-1];
                    opa_in       = a;
                    opb_n_in     = ~b;
                end
            end
        end else begin : g_src
            // Pick up the record and the still-unused operand bits from the previous stage.
            always_comb begin
                ctl_in   = g_stage[k-1].ctl_q;
                opa_in   = g_stage[k-1].g_pass.opa_q;
                opb_n_in = g_stage[k-1].g_pass.opb_n_q;
            end
        end

        cska_block #(
            .BLK (BLK)
        ) u_blk (
            .a    (opa_in[BLK-1:0]),
            .b_n  (opb_n_in[BLK-1:0]),
            .cin  (ctl_in.cin),
            .sum  (blk_sum),
            .cout (blk_cout),
            .prop (blk_prop)
        );

        if (k == 0) begin : g_diff
            // The first slice starts the de-skewed diff word.
            always_comb begin
                diff_d = blk_sum;
            end
        end else begin : g_diff
            // Append this slice above the diff bits already produced upstream.
            always_comb begin
                diff_d = {blk_sum, g_stage[k-1].diff_q};
            end
        end

        // Forward the block carry; a fully propagating block hands its incoming carry on.
        always_comb begin
            ctl_d     = ctl_in;
            ctl_d.cin = blk_prop ? ctl_in.cin : blk_cout;
        end

        // Stage register: cleared by reset, otherwise loads only on a global advance.
        always_ff @(posedge clk) begin
            if (rst) begin
                ctl_q  <= '0;
                diff_q <= '0;
            end else if (adv) begin
                ctl_q  <= ctl_d;
                diff_q <= diff_d;
            end
        end

        if (k < NBLK - 1) begin : g_pass
            logic [REM-BLK-1:0] opa_d;
            logic [REM-BLK-1:0] opa_q;
            logic [REM-BLK-1:0] opb_n_d;
            logic [REM-BLK-1:0] opb_n_q;

            // Operand bits of later blocks travel skewed to the stage that consumes them.
            always_comb begin
                opa_d   = opa_in[REM-1:BLK];
                opb_n_d = opb_n_in[REM-1:BLK];
            end

            // Operand delay register, same advance and reset as the stage record.
            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q   <= '0;
                    opb_n_q <= '0;
                end else if (adv) begin
                    opa_q   <= opa_d;
                    opb_n_q <= opb_n_d;
                end
            end
        end
    end

    // Result flags come from the last stage; borrow is the inverted final carry.
    always_comb begin
        out_valid = g_stage[NBLK-1].ctl_q.valid;
        diff      = g_stage[NBLK-1].diff_q;
        bout      = out_valid & ~g_stage[NBLK-1].ctl_q.cin;
        ovf       = out_valid & g_stage[NBLK-1].ctl_q.sx
                    & (g_stage[NBLK-1].ctl_q.sa ^ diff[WIDTH-1]);
    end

endmodule

// File: tb/tb_carryskip_subtractor_pipe.sv
// Scoreboard bench for carryskip_subtractor_pipe: directed cases, a mid-stream
// stall, a mid-stream reset and a randomized run against an arithmetic model.
module tb_carryskip_subtractor_pipe;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        int               acc_cyc;
        bit               chk_lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    carryskip_subtractor_pipe #(
        .WIDTH (WIDTH),
        .BLK   (BLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: plain integer subtraction, unsigned for borrow, signed for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic bi);
        exp_t        e;
        logic [31:0] full;
        int          sres;
        full   = {16'b0, av} - {16'b0, bv} - {31'b0, bi};
        e.diff = full[WIDTH-1:0];
        e.bout = (int'(av) < (int'(bv) + int'(bi)));
        sres   = int'($signed(av)) - int'($signed(bv)) - int'(bi);
        e.ovf  = (sres > 32767) || (sres < -32768);
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; records the expected result if the handshake completes.
    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic bi, input logic ordy, input bit lat, output bit accepted);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = av;
        b         = bv;
        bin       = bi;
        out_ready = ordy;
        @(negedge clk);
        accepted = v && (in_ready === 1'b1);
        if (accepted) begin
            e = model(av, bv, bi);
            e.acc_cyc = cyc + 1;
            e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic send_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic bi, input bit lat);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            apply_stimulus(1'b1, av, bv, bi, 1'b1, lat, acc);
            tries++;
        end
        check_output("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_diff", 32'(diff), 32'd0);
        check_output("rst_bout", 32'(bout), 32'd0);
        check_output("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_output("post_rst_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall behaviour.
    initial begin : monitor
        exp_t             e;
        logic             held_v;
        logic [WIDTH-1:0] held_diff;
        logic             held_bout;
        logic             held_ovf;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                held_v = 1'b0;
                continue;
            end
            if (held_v) begin
                check_output("hold_valid", 32'(out_valid), 32'd1);
                check_output("hold_diff", 32'(diff), 32'(held_diff));
                check_output("hold_bout", 32'(bout), 32'(held_bout));
                check_output("hold_ovf", 32'(ovf), 32'(held_ovf));
            end
            if (out_valid === 1'b1) begin
                if (out_ready === 1'b0) begin
                    check_output("stall_in_ready", 32'(in_ready), 32'd0);
                end else if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got diff=%0h with nothing expected", diff);
                end else begin
                    e = sb.pop_front();
                    check_output("diff", 32'(diff), 32'(e.diff));
                    check_output("bout", 32'(bout), 32'(e.bout));
                    check_output("ovf", 32'(ovf), 32'(e.ovf));
                    if (e.chk_lat) check_output("latency", 32'(cyc - e.acc_cyc), 32'(NBLK - 1));
                end
            end
            held_v    = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_diff = diff;
            held_bout = bout;
            held_ovf  = ovf;
        end
    end

    // Stimulus: directed cases, stall, reset mid-stream, random traffic, drain.
    initial begin : stimulus
        bit acc;
        int n_acc;
        int idx;
        int wait_cnt;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        do_reset();

        send_op(16'h1234, 16'h0234, 1'b0, 1'b1);
        idle(NBLK + 2);
        send_op(16'h0000, 16'h0001, 1'b0, 1'b1);
        idle(NBLK + 2);
        send_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        idle(NBLK + 2);
        send_op(16'h5555, 16'h5555, 1'b1, 1'b1);
        idle(NBLK + 2);
        send_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        idle(NBLK + 2);
        send_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        idle(NBLK + 2);

        n_acc = 0;
        idx   = 0;
        while (n_acc < 6 && idx < 50) begin
            apply_stimulus(1'b1, 16'(16'h1111 * (n_acc + 1)), 16'(16'h0F0F + n_acc * 3),
                           1'(n_acc % 2), !(idx >= 4 && idx <= 6), 1'b0, acc);
            if (acc) n_acc++;
            idx++;
        end
        check_output("stall_all_accepted", 32'(n_acc), 32'd6);
        idle(NBLK + 4);
        check_output("stall_drained", 32'(sb.size()), 32'd0);

        send_op(16'h0100, 16'h0001, 1'b0, 1'b0);
        send_op(16'h0200, 16'h0002, 1'b1, 1'b0);
        send_op(16'h0300, 16'h0003, 1'b0, 1'b0);
        do_reset();
        send_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
        idle(NBLK + 2);

        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            apply_stimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3) != 0, 1'b0, acc);
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 40) begin
            apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
            wait_cnt++;
        end
        check_output("final_drain", 32'(sb.size()), 32'd0);
        idle(NBLK + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
